// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
//   FWD_*  : EX operand source selects (ForwardA / ForwardB)
//   hz_state_t : hazard FSM state encoding (also exported on hz_state)
package pipeline_ctrl_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB   = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // operand from EX/MEM result

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2,
        HZ_RSVD  = 2'd3   // unused, recovers to HZ_RUN
    } hz_state_t;

endpackage

// File: rtl/hazard_forward_ctrl_forward_select.sv
// forward_select: forwarding source select for a single EX operand.
// Ports:
//   i_src_reg            register read by the EX-stage instruction
//   i_ex_mem_rd/_wr      EX/MEM destination and write enable
//   i_mem_wb_rd/_wr      MEM/WB destination and write enable
//   o_fwd                FWD_MEM / FWD_WB / FWD_NONE
// The younger EX/MEM result wins when both stages match.
module forward_select
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src_reg,
    input  logic [REG_ADDR_W-1:0] i_ex_mem_rd,
    input  logic                  i_ex_mem_wr,
    input  logic [REG_ADDR_W-1:0] i_mem_wb_rd,
    input  logic                  i_mem_wb_wr,
    output logic [1:0]            o_fwd
);

    logic w_hit_mem;
    logic w_hit_wb;

    // Register 0 is hard-wired zero, so a write to it never forwards.
    assign w_hit_mem = i_ex_mem_wr && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_src_reg);
    assign w_hit_wb  = i_mem_wb_wr && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_src_reg);

    always_comb begin
        o_fwd = FWD_NONE;
        if (w_hit_mem) begin
            o_fwd = FWD_MEM;
        end else if (w_hit_wb) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, branch flush and EX forwarding control
// for the 5-stage pipeline.
//
// Parameters: REG_ADDR_W (register address width), LOAD_LATENCY (bubbles per
// load-use hazard, 1..7), CNT_W (stall counter width, 2**CNT_W > LOAD_LATENCY).
//
// Ports:
//   clock, reset            pipeline clock, synchronous active-high reset
//   if_id_* / id_ex_*       hazard-detect operands
//   ex_mem_* / mem_wb_*     forwarding candidates
//   branch_taken            PCSrc resolved in MEM
//   PCWrite, IF_ID_Write    front-end hold (0 = hold)
//   stall_mux               zero ID/EX control bits (bubble)
//   flush_if_id/_id_ex/_ex_mem  stage squash strobes
//   ForwardA, ForwardB      EX operand source selects
//   hz_state                FSM state for the debug UART
//   stall_cycles, flush_events  saturating perf counters (HAZARD_PERF_EN only)
//
// Build option: define HAZARD_PERF_EN to add the performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HZ_RUN   | normal flow; detect load-use and taken branches
// HZ_STALL | extra load-use bubbles, r_cnt counts remaining ones
// HZ_FLUSH | one cycle squashing the wrong-path fetch of the branch cycle
module hazard_forward_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rs,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    input  logic                  branch_taken,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  stall_mux,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
`ifdef HAZARD_PERF_EN
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_events,
`endif
    output logic [1:0]            hz_state
);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lu;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_lu = id_ex_mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = HZ_RUN;
        w_cnt_nxt    = '0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        stall_mux    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;

        case (r_state)
            HZ_RUN: begin
                if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    w_state_nxt  = HZ_FLUSH;
                end else if (w_lu) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    stall_mux   = 1'b1;
                    // This cycle is the first bubble; STALL supplies the rest.
                    if (LOAD_LATENCY > 1) begin
                        w_state_nxt = HZ_STALL;
                        w_cnt_nxt   = CNT_W'(LOAD_LATENCY - 1);
                    end
                end
            end
            HZ_STALL: begin
                if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    w_state_nxt  = HZ_FLUSH;
                end else begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    stall_mux   = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_state_nxt = (r_cnt == CNT_W'(1)) ? HZ_RUN : HZ_STALL;
                end
            end
            HZ_FLUSH: begin
                // Load-use is ignored here: the IF/ID contents are being squashed.
                if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    w_state_nxt  = HZ_FLUSH;
                end else begin
                    flush_if_id = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HZ_RUN;
            end
        endcase

        if (reset) begin
            w_state_nxt  = HZ_RUN;
            w_cnt_nxt    = '0;
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            stall_mux    = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
        end
    end

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_src_reg   (id_ex_rs),
        .i_ex_mem_rd (ex_mem_rd),
        .i_ex_mem_wr (ex_mem_reg_write),
        .i_mem_wb_rd (mem_wb_rd),
        .i_mem_wb_wr (mem_wb_reg_write),
        .o_fwd       (w_fwd_a)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_src_reg   (id_ex_rt),
        .i_ex_mem_rd (ex_mem_rd),
        .i_ex_mem_wr (ex_mem_reg_write),
        .i_mem_wb_rd (mem_wb_rd),
        .i_mem_wb_wr (mem_wb_reg_write),
        .o_fwd       (w_fwd_b)
    );

    assign ForwardA = reset ? FWD_NONE : w_fwd_a;
    assign ForwardB = reset ? FWD_NONE : w_fwd_b;
    assign hz_state = reset ? HZ_RUN : r_state;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;
    logic        w_flush_entry;

    assign w_flush_entry = ((r_state == HZ_RUN) || (r_state == HZ_STALL)) &&
                           (w_state_nxt == HZ_FLUSH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_mux && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_flush_entry && (r_flush_events != 16'hFFFF)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl. Two instances share the stimulus:
// d1 built with LOAD_LATENCY=1, d3 with LOAD_LATENCY=3. Control outputs are
// compared as one vector {PCWrite, IF_ID_Write, stall_mux, flush_if_id,
// flush_id_ex, flush_ex_mem, hz_state}.
module tb_hazard_forward_ctrl;

    localparam logic [7:0] C_NEUTRAL  = 8'b110_000_00;
    localparam logic [7:0] C_LU_RUN   = 8'b001_000_00;
    localparam logic [7:0] C_LU_STALL = 8'b001_000_01;
    localparam logic [7:0] C_BR_RUN   = 8'b110_111_00;
    localparam logic [7:0] C_BR_STALL = 8'b110_111_01;
    localparam logic [7:0] C_BR_FLUSH = 8'b110_111_10;
    localparam logic [7:0] C_FLUSH    = 8'b110_100_10;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
    logic       if_id_uses_rt, id_ex_mem_read, ex_mem_reg_write, mem_wb_reg_write;
    logic       branch_taken;

    logic       pcw1, ifw1, sm1, fa1, fb1, fc1;
    logic       pcw3, ifw3, sm3, fa3, fb3, fc3;
    logic [1:0] fwa1, fwb1, hz1, fwa3, fwb3, hz3;
`ifdef HAZARD_PERF_EN
    logic [15:0] sc1, fe1, sc3, fe3;
`endif

    logic [7:0] w_c1, w_c3;
    assign w_c1 = {pcw1, ifw1, sm1, fa1, fb1, fc1, hz1};
    assign w_c3 = {pcw3, ifw3, sm3, fa3, fb3, fc3, hz3};

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(3)) d1 (
        .clock(clock), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .branch_taken(branch_taken),
        .PCWrite(pcw1), .IF_ID_Write(ifw1), .stall_mux(sm1),
        .flush_if_id(fa1), .flush_id_ex(fb1), .flush_ex_mem(fc1),
        .ForwardA(fwa1), .ForwardB(fwb1),
`ifdef HAZARD_PERF_EN
        .stall_cycles(sc1), .flush_events(fe1),
`endif
        .hz_state(hz1)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(3)) d3 (
        .clock(clock), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .branch_taken(branch_taken),
        .PCWrite(pcw3), .IF_ID_Write(ifw3), .stall_mux(sm3),
        .flush_if_id(fa3), .flush_id_ex(fb3), .flush_ex_mem(fc3),
        .ForwardA(fwa3), .ForwardB(fwb3),
`ifdef HAZARD_PERF_EN
        .stall_cycles(sc3), .flush_events(fe3),
`endif
        .hz_state(hz3)
    );

    task automatic clr_inputs();
        if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
        id_ex_mem_read = 1'b0; id_ex_rs = 5'd0; id_ex_rt = 5'd0;
        ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b0;
        mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1; id_ex_rs = 5'd3;
        branch_taken = 1'b1;
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL reset_ctl: got %b want %b", w_c3, C_NEUTRAL);
        end
        tests_run++;
        if ({fwa3, fwb3} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_fwd: got %b want 0000", {fwa3, fwb3});
        end
        clr_inputs();
        reset = 1'b0;
        #1;
        tests_run++;
        if (w_c1 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL reset_release: got %b want %b", w_c1, C_NEUTRAL);
        end
    endtask

    task automatic test_lu_lat1();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        #1;
        tests_run++;
        if (w_c1 !== C_LU_RUN) begin
            tests_failed++; $display("FAIL lat1_stall: got %b want %b", w_c1, C_LU_RUN);
        end
        next_cycle();
        id_ex_mem_read = 1'b0;
        #1;
        tests_run++;
        if (w_c1 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL lat1_after: got %b want %b", w_c1, C_NEUTRAL);
        end
    endtask

    task automatic test_lu_lat3();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        #1;
        tests_run++;
        if (w_c3 !== C_LU_RUN) begin
            tests_failed++; $display("FAIL lat3_c1: got %b want %b", w_c3, C_LU_RUN);
        end
        next_cycle();
        id_ex_mem_read = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_LU_STALL) begin
            tests_failed++; $display("FAIL lat3_c2: got %b want %b", w_c3, C_LU_STALL);
        end
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_LU_STALL) begin
            tests_failed++; $display("FAIL lat3_c3: got %b want %b", w_c3, C_LU_STALL);
        end
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL lat3_c4: got %b want %b", w_c3, C_NEUTRAL);
        end
`ifdef HAZARD_PERF_EN
        tests_run++;
        if (sc3 !== 16'd3) begin
            tests_failed++; $display("FAIL lat3_perf: got %0d want 3", sc3);
        end
`endif
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        next_cycle();
        id_ex_mem_read = 1'b0; branch_taken = 1'b1;
        #1;
        tests_run++;
        if (w_c3 !== C_BR_STALL) begin
            tests_failed++; $display("FAIL brstall_abort: got %b want %b", w_c3, C_BR_STALL);
        end
        next_cycle();
        branch_taken = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_FLUSH) begin
            tests_failed++; $display("FAIL brstall_flush: got %b want %b", w_c3, C_FLUSH);
        end
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL brstall_run: got %b want %b", w_c3, C_NEUTRAL);
        end
    endtask

    task automatic test_branch_in_run();
        do_reset();
        branch_taken = 1'b1;
        // A load-use hazard in the branch cycle loses to the branch.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
        #1;
        tests_run++;
        if (w_c3 !== C_BR_RUN) begin
            tests_failed++; $display("FAIL brrun_c1: got %b want %b", w_c3, C_BR_RUN);
        end
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_BR_FLUSH) begin
            tests_failed++; $display("FAIL brrun_reenter: got %b want %b", w_c3, C_BR_FLUSH);
        end
        next_cycle();
        branch_taken = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_FLUSH) begin
            tests_failed++; $display("FAIL brrun_flush_lu_suppr: got %b want %b", w_c3, C_FLUSH);
        end
        next_cycle();
        id_ex_mem_read = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL brrun_run: got %b want %b", w_c3, C_NEUTRAL);
        end
    endtask

    task automatic test_forward();
        do_reset();
        id_ex_rs = 5'd5; id_ex_rt = 5'd6;
        ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1;
        mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1;
        #1;
        tests_run++;
        if ({fwa3, fwb3} !== 4'b1000) begin
            tests_failed++; $display("FAIL fwd_double: got %b want 1000", {fwa3, fwb3});
        end
        ex_mem_reg_write = 1'b0;
        #1;
        tests_run++;
        if ({fwa3, fwb3} !== 4'b0100) begin
            tests_failed++; $display("FAIL fwd_wb: got %b want 0100", {fwa3, fwb3});
        end
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs = 5'd0;
        #1;
        tests_run++;
        if ({fwa3, fwb3} !== 4'b0000) begin
            tests_failed++; $display("FAIL fwd_r0: got %b want 0000", {fwa3, fwb3});
        end
        id_ex_rs = 5'd9; ex_mem_rd = 5'd6; mem_wb_rd = 5'd6;
        #1;
        tests_run++;
        if ({fwa1, fwb1} !== 4'b0010) begin
            tests_failed++; $display("FAIL fwdb_mem: got %b want 0010", {fwa1, fwb1});
        end
        ex_mem_rd = 5'd9;
        #1;
        tests_run++;
        if ({fwa1, fwb1} !== 4'b1001) begin
            tests_failed++; $display("FAIL fwd_split: got %b want 1001", {fwa1, fwb1});
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_uses_rt = 1'b1;
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL nostall_r0: got %b want %b", w_c3, C_NEUTRAL);
        end
        id_ex_rt = 5'd4; if_id_rs = 5'd7; if_id_rt = 5'd4; if_id_uses_rt = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL nostall_rt_unused: got %b want %b", w_c3, C_NEUTRAL);
        end
        if_id_uses_rt = 1'b1;
        #1;
        tests_run++;
        if (w_c1 !== C_LU_RUN) begin
            tests_failed++; $display("FAIL stall_rt_used: got %b want %b", w_c1, C_LU_RUN);
        end
        id_ex_mem_read = 1'b0;
        #1;
        tests_run++;
        if (w_c1 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL nostall_noload: got %b want %b", w_c1, C_NEUTRAL);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        next_cycle();
        id_ex_mem_read = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL rststall_during: got %b want %b", w_c3, C_NEUTRAL);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL rststall_after: got %b want %b", w_c3, C_NEUTRAL);
        end
        next_cycle();
        #1;
        tests_run++;
        if (w_c3 !== C_NEUTRAL) begin
            tests_failed++; $display("FAIL rststall_after2: got %b want %b", w_c3, C_NEUTRAL);
        end
`ifdef HAZARD_PERF_EN
        tests_run++;
        if ({sc3, fe3} !== 32'd0) begin
            tests_failed++; $display("FAIL rststall_perf: got %h want 0", {sc3, fe3});
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
        test_reset();
        test_lu_lat1();
        test_lu_lat3();
        test_branch_in_stall();
        test_branch_in_run();
        test_forward();
        test_no_stall();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Unified, parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises the single-cycle load-use stall to a configurable memory latency and adds branch-flush control with a stall state machine. It also generates the EX operand forwarding selects. It sits beside IF/ID/EX/MEM and drives PCWrite, IF_ID_Write, stall_mux, the stage flush strobes and ForwardA/ForwardB.

Parameters:
REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero.
LOAD_LATENCY, 1, total bubble cycles inserted on a load-use hazard; range 1..7.
CNT_W, 3, stall down-counter width; must satisfy 2^CNT_W > LOAD_LATENCY.

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
if_id_rs  in  REG_ADDR_W  rs of the instruction in IF/ID
if_id_rt  in  REG_ADDR_W  rt of the instruction in IF/ID
if_id_uses_rt  in  1  1 = IF/ID instruction reads rt
id_ex_mem_read  in  1  ID/EX holds a load
id_ex_rs  in  REG_ADDR_W  rs of the ID/EX instruction
id_ex_rt  in  REG_ADDR_W  rt of the ID/EX instruction (load destination)
ex_mem_rd  in  REG_ADDR_W  EX/MEM destination
ex_mem_reg_write  in  1  EX/MEM writes the register file
mem_wb_rd  in  REG_ADDR_W  MEM/WB destination
mem_wb_reg_write  in  1  MEM/WB writes the register file
branch_taken  in  1  PCSrc resolved in MEM
PCWrite  out  1  1 = PC may update
IF_ID_Write  out  1  1 = IF/ID may load
stall_mux  out  1  1 = zero the ID/EX control bits (bubble)
flush_if_id  out  1  squash IF/ID
flush_id_ex  out  1  squash ID/EX
flush_ex_mem  out  1  squash EX/MEM
ForwardA  out  2  operand-A source select
ForwardB  out  2  operand-B source select
hz_state  out  2  FSM state, for the debug UART

Behaviour:
- Reset (reset=1 at a clock edge):
  - State RUN, counter 0.
  - While reset is high, outputs are forced to PCWrite=1, IF_ID_Write=1, stall_mux=0, all flushes 0, ForwardA/B=00, hz_state=RUN.
- Load-use detect (combinational): lu = id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- FSM states: RUN=0, STALL=1, FLUSH=2. Encoding 3 is unused and returns to RUN.
- RUN, priority order:
  - branch_taken: flush_if_id=flush_id_ex=flush_ex_mem=1 this cycle; PCWrite=1; next state FLUSH.
  - else lu: PCWrite=0, IF_ID_Write=0, stall_mux=1 this cycle. If LOAD_LATENCY>1, next state STALL with cnt=LOAD_LATENCY-1; else stay in RUN.
  - else all neutral.
- STALL:
  - PCWrite=0, IF_ID_Write=0, stall_mux=1.
  - cnt decrements each cycle; when cnt==1 the next state is RUN.
  - The total number of bubbles is exactly LOAD_LATENCY.
  - id_ex_mem_read is ignored while in STALL.
  - branch_taken in STALL aborts the stall: flushes asserted, PCWrite=1, IF_ID_Write=1, stall_mux=0, cnt cleared, next state FLUSH.
- FLUSH:
  - Lasts one cycle: flush_if_id=1 only, so the wrong-path fetch issued in the branch cycle is squashed.
  - lu is suppressed.
  - Next state RUN; a further branch_taken re-enters FLUSH.
- Forwarding (combinational, independent of the FSM):
  - ForwardA=10 if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==id_ex_rs.
  - Else 01 if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==id_ex_rs.
  - Else 00.
  - ForwardB is identical, using id_ex_rt.
  - EX/MEM wins over MEM/WB on a double match.
- Reset mid-stall: the stall is abandoned and outputs are neutral on the next cycle.
- Latency: all outputs are combinational from the current inputs plus registered state. There is no added pipeline delay.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds two 16-bit saturating counters.
  - stall_cycles increments every cycle stall_mux=1.
  - flush_events increments on each RUN/STALL→FLUSH transition.
  - Both are cleared by reset, saturate at 16'hFFFF, and are exposed as output ports stall_cycles and flush_events for the debug UART.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipeline_ctrl_pkg:
  - Forward-select constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Hazard state constants HZ_RUN, HZ_STALL, HZ_FLUSH.
- One natural sub-module: forward_select (comparator/priority logic for one operand), instanced twice (A with id_ex_rs, B with id_ex_rt).

Test Plan:
1. LOAD_LATENCY=1: id_ex_mem_read=1, id_ex_rt=3, if_id_rs=3 -> exactly 1 cycle of PCWrite=0, IF_ID_Write=0, stall_mux=1; state stays RUN.
2. LOAD_LATENCY=3, same hazard -> 3 consecutive stall cycles (hz_state 0→1→1→0); id_ex_mem_read dropped after cycle 1 does not shorten the stall.
3. LOAD_LATENCY=3, branch_taken in the 2nd stall cycle -> all three flushes=1, PCWrite=1 that cycle; next cycle flush_if_id only; then RUN with neutral outputs.
4. ex_mem_rd=5/wr=1, mem_wb_rd=5/wr=1, id_ex_rs=5 -> ForwardA=10; ex_mem_reg_write=0 -> ForwardA=01; rd=0 on both -> ForwardA=00.
5. Hazard with id_ex_rt=0, or if_id_uses_rt=0 with rt match only -> no stall.
6. reset=1 asserted in STALL -> neutral outputs while high, state RUN afterwards; with HAZARD_PERF_EN both counters read 0.
